// File: rtl/mux_scan_if.sv
// Handshake and mux-control bundle between a scan controller and its host/mux.
// The word_parity signal exists only when MUX_SCAN_PARITY_EN is defined.
interface mux_scan_if;
  logic       start;
  logic       cont;
  logic       mux_out;
  logic       s1;
  logic       s0;
  logic [3:0] sample_word;
  logic       word_valid;
  logic       busy;
`ifdef MUX_SCAN_PARITY_EN
  logic       word_parity;

  modport master (
    output start, cont, mux_out,
    input  s1, s0, sample_word, word_valid, busy, word_parity
  );
  modport slave (
    input  start, cont, mux_out,
    output s1, s0, sample_word, word_valid, busy, word_parity
  );
`else
  modport master (
    output start, cont, mux_out,
    input  s1, s0, sample_word, word_valid, busy
  );
  modport slave (
    input  start, cont, mux_out,
    output s1, s0, sample_word, word_valid, busy
  );
`endif
endinterface

// File: rtl/mux_scan_ctrl.sv
// Scans a 4:1 mux over channels 0..3, settling SETTLE_CYC cycles per channel, and
// publishes the assembled 4-bit word. MUX_SCAN_PARITY_EN adds an even-parity output.
module mux_scan_ctrl #(
  parameter int unsigned SETTLE_CYC = 1
) (
  input  logic      clk,
  input  logic      rst_n,
  mux_scan_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYC - 1);

  state_t     state_q, state_d;
  logic [1:0] ch_q, ch_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] shadow_q, shadow_d;
  logic [3:0] word_q, word_d;
  logic       par_q, par_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ch_q     <= 2'd0;
      cnt_q    <= 4'd0;
      shadow_q <= 4'd0;
      word_q   <= 4'd0;
      par_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ch_q     <= ch_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      word_q   <= word_d;
      par_q    <= par_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ch_d     = ch_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    word_d   = word_q;
    par_d    = par_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = SETTLE;
          ch_d    = 2'd0;
          cnt_d   = 4'd0;
        end
      end
      SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          state_d = SAMPLE;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      SAMPLE: begin
        shadow_d[ch_q] = bus.mux_out;
        if (ch_q == 2'd3) begin
          // The last bit bypasses the shadow so the word is complete on entry to DONE.
          state_d = DONE;
          word_d  = {bus.mux_out, shadow_q[2:0]};
          par_d   = ^{bus.mux_out, shadow_q[2:0]};
        end else begin
          state_d = SETTLE;
          ch_d    = ch_q + 2'd1;
          cnt_d   = 4'd0;
        end
      end
      DONE: begin
        if (bus.cont) begin
          state_d = SETTLE;
          ch_d    = 2'd0;
          cnt_d   = 4'd0;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The select lines are the registered channel index itself.
  assign bus.s1          = ch_q[1];
  assign bus.s0          = ch_q[0];
  assign bus.sample_word = word_q;
  assign bus.word_valid  = (state_q == DONE);
  assign bus.busy        = (state_q != IDLE);
`ifdef MUX_SCAN_PARITY_EN
  assign bus.word_parity = par_q;
`else
  logic unused_par;
  assign unused_par = par_q;
`endif

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Bench for mux_scan_ctrl: two instances (SETTLE_CYC=1 and 3) checked cycle by cycle
// against a scan-timeline model, plus directed scenario checks.
module tb_mux_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       cont;
  logic [3:0] in_v [2];

  always #5 clk = ~clk;

  mux_scan_if b1 ();
  mux_scan_if b3 ();

  assign b1.start   = start;
  assign b1.cont    = cont;
  assign b1.mux_out = in_v[0][{b1.s1, b1.s0}];
  assign b3.start   = start;
  assign b3.cont    = cont;
  assign b3.mux_out = in_v[1][{b3.s1, b3.s0}];

  mux_scan_ctrl #(.SETTLE_CYC(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));
  mux_scan_ctrl #(.SETTLE_CYC(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(b3.slave));

  // {busy, word_valid, s1, s0, sample_word, parity}
  logic [8:0] obs [2];
`ifdef MUX_SCAN_PARITY_EN
  assign obs[0] = {b1.busy, b1.word_valid, b1.s1, b1.s0, b1.sample_word, b1.word_parity};
  assign obs[1] = {b3.busy, b3.word_valid, b3.s1, b3.s0, b3.sample_word, b3.word_parity};
`else
  assign obs[0] = {b1.busy, b1.word_valid, b1.s1, b1.s0, b1.sample_word, 1'b0};
  assign obs[1] = {b3.busy, b3.word_valid, b3.s1, b3.s0, b3.sample_word, 1'b0};
`endif

  int checks = 0;
  int errors = 0;

  // Scan timeline model: k = cycle number within the current scan (1 = first cycle after acceptance).
  bit         act_m   [2];
  int         k_m     [2];
  logic [1:0] sel_m   [2];
  logic [3:0] sh_m    [2];
  logic [3:0] word_m  [2];
  int         edge_n = 0;
  int         acc_edge[2];
  int         wv_edge [2];
  int         wv_cnt  [2];
  int         last_gap[2];
  bit         prev_wv [2];

  function automatic int settle_of(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs_v, input logic [15:0] exp_v);
    checks++;
    assert (obs_v === exp_v) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs_v, exp_v);
    end
  endtask

  task automatic step();
    logic [8:0] exp_v;
    @(posedge clk);
    edge_n++;
    for (int d = 0; d < 2; d++) begin
      int s = settle_of(d);
      int l = 4 * (s + 1);
      if (!rst_n) begin
        act_m[d] = 0; k_m[d] = 0; sel_m[d] = 2'd0; sh_m[d] = 4'd0; word_m[d] = 4'd0;
      end else if (!act_m[d]) begin
        if (start) begin
          act_m[d] = 1; k_m[d] = 1; sel_m[d] = 2'd0; acc_edge[d] = edge_n;
        end
      end else if (k_m[d] <= l) begin
        // The last cycle of each channel's slot captures that channel's mux input.
        if (k_m[d] % (s + 1) == 0) begin
          int ci = k_m[d] / (s + 1) - 1;
          sh_m[d][ci] = in_v[d][ci];
        end
        k_m[d]++;
        if (k_m[d] <= l) sel_m[d] = 2'((k_m[d] - 1) / (s + 1));
        else             word_m[d] = sh_m[d];
      end else begin
        if (cont) begin
          k_m[d] = 1; sel_m[d] = 2'd0; acc_edge[d] = edge_n;
        end else begin
          act_m[d] = 0;
        end
      end
    end
    #1;
    for (int d = 0; d < 2; d++) begin
      int l = 4 * (settle_of(d) + 1);
      bit wv_e = act_m[d] && (k_m[d] == l + 1);
`ifdef MUX_SCAN_PARITY_EN
      exp_v = {act_m[d], wv_e, sel_m[d], word_m[d], ^word_m[d]};
`else
      exp_v = {act_m[d], wv_e, sel_m[d], word_m[d], 1'b0};
`endif
      chk((d == 0) ? "cycle_s1" : "cycle_s3", 16'(obs[d]), 16'(exp_v));
      if (obs[d][7]) begin
        chk("wv_not_consecutive", 16'(prev_wv[d]), 16'd0);
        // word_valid occupies the cycle that begins 4*(S+1) edges after acceptance.
        chk("latency", 16'(edge_n - acc_edge[d]), 16'(l));
        wv_cnt[d]++;
        last_gap[d] = edge_n - wv_edge[d];
        wv_edge[d]  = edge_n;
      end
      prev_wv[d] = obs[d][7];
    end
  endtask

  task automatic clear_counts();
    for (int d = 0; d < 2; d++) wv_cnt[d] = 0;
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      act_m[d] = 0; k_m[d] = 0; sel_m[d] = 2'd0; sh_m[d] = 4'd0; word_m[d] = 4'd0;
      acc_edge[d] = 0; wv_edge[d] = 0; wv_cnt[d] = 0; last_gap[d] = 0; prev_wv[d] = 0;
      in_v[d] = 4'd0;
    end
    rst_n = 1'b0; start = 1'b0; cont = 1'b0;
    repeat (3) step();
    chk("reset_s1", 16'(obs[0]), 16'd0);
    chk("reset_s3", 16'(obs[1]), 16'd0);

    // Single scan from the first edge out of reset; i0..i3 = 1,0,1,1 and all ones.
    rst_n = 1'b1; start = 1'b1; in_v[0] = 4'b1101; in_v[1] = 4'b1111;
    step();
    start = 1'b0;
    repeat (20) step();
    chk("scan1_word", 16'(b1.sample_word), 16'h000D);
    chk("scan3_word", 16'(b3.sample_word), 16'h000F);
    chk("scan1_count", 16'(wv_cnt[0]), 16'd1);
    chk("scan3_count", 16'(wv_cnt[1]), 16'd1);
`ifdef MUX_SCAN_PARITY_EN
    chk("scan1_parity", 16'(b1.word_parity), 16'd1);
    chk("scan3_parity", 16'(b3.word_parity), 16'd0);
`endif

    // start held high: one scan per IDLE entry, no restart while busy.
    clear_counts();
    in_v[0] = 4'b0010; in_v[1] = 4'($urandom);
    start = 1'b1;
    repeat (20) step();
    start = 1'b0;
    repeat (20) step();
    chk("held_word", 16'(b1.sample_word), 16'h0002);
    chk("held_count1", 16'(wv_cnt[0]), 16'd2);
    chk("held_count3", 16'(wv_cnt[1]), 16'd2);

    // Continuous mode with the inputs swapped after every word.
    clear_counts();
    in_v[0] = 4'b0001; in_v[1] = 4'b0001;
    cont = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    repeat (60) begin
      step();
      if (b1.word_valid) in_v[0] = (in_v[0] == 4'b0001) ? 4'b1000 : 4'b0001;
      if (b3.word_valid) in_v[1] = (in_v[1] == 4'b0001) ? 4'b1000 : 4'b0001;
    end
    chk("cont_gap1", 16'(last_gap[0]), 16'd9);
    chk("cont_gap3", 16'(last_gap[1]), 16'd17);
    chk("cont_many1", 16'(wv_cnt[0] >= 6), 16'd1);
    cont = 1'b0;
    repeat (25) step();

    // Reset while the SETTLE_CYC=1 instance settles channel 2.
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (4) step();
    chk("abort_pre_sel", 16'({b1.busy, b1.s1, b1.s0}), 16'b110);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("abort_idle1", 16'(obs[0]), 16'd0);
    chk("abort_idle3", 16'(obs[1]), 16'd0);
    clear_counts();
    repeat (25) step();
    chk("abort_no_wv1", 16'(wv_cnt[0]), 16'd0);
    chk("abort_no_wv3", 16'(wv_cnt[1]), 16'd0);

    // Randomised traffic, including sporadic resets and inputs changing every cycle.
    repeat (800) begin
      rst_n   = ($urandom_range(0, 59) != 0);
      start   = 1'($urandom);
      cont    = ($urandom_range(0, 2) == 0);
      in_v[0] = 4'($urandom);
      in_v[1] = 4'($urandom);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux_scan_ctrl.md
MUX_SCAN_CTRL -- requirements
Module: mux_scan_ctrl

Interface
REQ-001 SHALL have parameter: SETTLE_CYC, 1, number of cycles the select is held before mux_out is sampled (legal 1..15).
REQ-002 SHALL have port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port: start  input  1  begin one scan of mux channels 0..3; sampled only in IDLE.
REQ-005 SHALL have port: cont  input  1  continuous mode; sampled in DONE; 1 = rescan immediately.
REQ-006 SHALL have port: mux_out  input  1  data output of the downstream 4:1 mux.
REQ-007 SHALL have port: s1  output  1  mux select MSB (registered).
REQ-008 SHALL have port: s0  output  1  mux select LSB (registered).
REQ-009 SHALL have port: sample_word  output  4  assembled scan result; bit i = mux_out captured while {s1,s0}=i.
REQ-010 SHALL have port: word_valid  output  1  one-cycle pulse, sample_word updated this cycle.
REQ-011 SHALL have port: busy  output  1  high in every state except IDLE.

Function
REQ-012 SHALL implement FSM states IDLE, SETTLE, SAMPLE, DONE, with a 2-bit channel index ch and a 4-bit settle counter.
REQ-013 IDLE: start=1 -> SETTLE, ch=0, {s1,s0}=00, counter cleared; start=0 -> stay IDLE.
REQ-014 SETTLE: {s1,s0} held at ch; counter increments each cycle; after SETTLE_CYC cycles -> SAMPLE.
REQ-015 SAMPLE: one cycle; at its end mux_out is captured into internal shadow bit ch; ch<3 -> ch+1, {s1,s0}=ch+1, SETTLE; ch=3 -> DONE.
REQ-016 DONE: one cycle; sample_word loaded from shadow register, word_valid=1; cont=1 -> SETTLE with ch=0, {s1,s0}=00; cont=0 -> IDLE.
REQ-017 Latency: word_valid SHALL assert exactly 4*(SETTLE_CYC+1)+1 cycles after the edge on which start was accepted.
REQ-018 Select SHALL only change on the transition out of SAMPLE or into SETTLE from IDLE/DONE; never during SETTLE.
REQ-019 start asserted while busy=1 SHALL be ignored (no restart, no queuing).
REQ-020 sample_word SHALL hold its value between word_valid pulses; shadow bits SHALL not be visible until DONE.
REQ-021 word_valid SHALL never be high on two consecutive cycles, including in continuous mode.
REQ-022 ch wrap 3->0 SHALL occur only via DONE, never directly from SAMPLE.

Reset
REQ-023 rst_n=0 at a clock edge SHALL force IDLE, ch=0, counter=0, {s1,s0}=00, sample_word=0, shadow=0, word_valid=0, busy=0, regardless of state (mid-scan scan discarded, no word_valid).
REQ-024 First start SHALL be accepted on the first edge with rst_n=1.

Configuration
REQ-025 Macro MUX_SCAN_PARITY_EN defined: SHALL add output word_parity (1 bit) = XOR of the four bits loaded into sample_word, updated in DONE with sample_word, reset to 0.
REQ-026 Macro MUX_SCAN_PARITY_EN undefined: port word_parity and its logic SHALL be absent; all other behaviour identical.

Verification
REQ-027 Reset then mux inputs i0..i3=1,0,1,1, SETTLE_CYC=1, start pulse -> select sequence 00,01,10,11 each 2 cycles, word_valid at cycle 9, sample_word=4'b1101, word_parity=1 (macro on).
REQ-028 Inputs 0,1,0,0, start held high 20 cycles, cont=0 -> exactly one scan per IDLE entry: word_valid cycle 9 then restart, sample_word=4'b0010; start during busy ignored.
REQ-029 cont=1, inputs changed 1,0,0,0 -> 0,0,0,1 between scans -> consecutive word_valid pulses 9 cycles apart, words 4'b0001 then 4'b1000.
REQ-030 rst_n low for one cycle while ch=2 in SETTLE -> next cycle IDLE, outputs all 0, no word_valid for aborted scan.
REQ-031 SETTLE_CYC=3, inputs all 1 -> each select held 4 cycles, word_valid 17 cycles after start, sample_word=4'b1111, word_parity=0.
